franken_dmem: RTL

FRANKEN_DMEM -- requirements
Module: franken_dmem

---
 rtl/franken_dmem.sv | 124 ++++++++++++
 1 files changed

// File: rtl/franken_dmem.sv
// Serialised data memory for a single-issue core: one access in flight, fixed wait states,
// word-indexed DEPTH x 32 storage with per-lane store mask and out-of-range detection.
module franken_dmem #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        resp_valid,
  output logic        busy,
  output logic        addr_error
);

  localparam int          AW        = $clog2(DEPTH);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [31:2]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_read_data;
  logic          r_addr_error;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_acc_write;
  logic [31:2]   w_acc_addr;
  logic [3:0]    w_acc_be;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_word;
  logic          w_oor;
  logic          w_unused_addr_lsbs;

  // Byte offset is resolved upstream; only word-granular bits take part in the access.
  assign w_unused_addr_lsbs = &{1'b0, addr[1:0]};

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With no wait states the access completes on the accepting edge, so it must use the live
  // request; otherwise only the latched copy is looked at.
  assign w_acc_write = (r_state == S_IDLE) ? req_write         : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? addr[31:2]        : r_addr;
  assign w_acc_be    = (r_state == S_IDLE) ? byte_enable       : r_be;
  assign w_acc_wdata = (r_state == S_IDLE) ? write_data        : r_wdata;

  assign w_word = w_acc_addr[AW+1:2];
  assign w_oor  = |w_acc_addr[31:AW+2];

  // Gated by reset so an edge seen while reset is held can never commit a store.
  assign w_enter_resp = reset &&
                        (NO_WAIT ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = NO_WAIT ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_read_data  <= 32'd0;
      r_addr_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= addr[31:2];
        r_be    <= byte_enable;
        r_wdata <= write_data;
        r_cnt   <= WAIT_LOAD;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp && !w_acc_write) begin
        r_read_data <= w_oor ? 32'd0 : r_mem[w_word];
      end
      r_addr_error <= w_enter_resp && w_oor;
    end
  end

  // NOTE: the storage array has no reset; clearing DEPTH words would cost a reset tree for
  // every bit and its contents are defined only by stores.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc_write && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) r_mem[w_word][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

  assign read_data  = r_read_data;
  assign resp_valid = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign addr_error = r_addr_error;

endmodule
